// File: rtl/mac_entry_sequencer.sv
// Front-panel controller for the FP MAC: collects two hex operands from the keypad,
// issues one MAC operation with a timeout and drives the hex display and stage LEDs.
module mac_entry_sequencer #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  ns_pulse,
  input  logic                  acc_clr,
  output logic [4*DIGITS-1:0]   mac_a,
  output logic [4*DIGITS-1:0]   mac_b,
  output logic                  mac_start,
  output logic                  mac_clr_acc,
  input  logic                  mac_done,
  input  logic [4*DIGITS-1:0]   mac_result,
  output logic [4*DIGITS-1:0]   disp_value,
  output logic [4:0]            stage_out
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(MAC_TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(MAC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StEnterA,
    StEnterB,
    StIssue,
    StWait,
    StShow,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  disp_q, disp_d;
  logic [4:0]    stage_q, stage_d;
  logic          start_q, start_d;
  logic          clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;

    if (acc_clr) begin
      clr_d   = 1'b1;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      cnt_d   = '0;
      state_d = StEnterA;
    end else begin
      case (state_q)
        StEnterA: begin
          if (ns_pulse) begin
            b_d     = '0;
            state_d = StEnterB;
          end else if (key_valid) begin
            a_d = {a_q[W-5:0], key_code};
          end
        end
        StEnterB: begin
          if (ns_pulse) begin
            state_d = StIssue;
          end else if (key_valid) begin
            b_d = {b_q[W-5:0], key_code};
          end
        end
        StIssue: begin
          cnt_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          // Completion beats a timeout landing in the same cycle.
          if (mac_done) begin
            res_d   = mac_result;
            state_d = StShow;
          end else if (cnt_q == CntLast) begin
            state_d = StErr;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StShow: begin
          if (ns_pulse) begin
            a_d     = '0;
            state_d = StEnterA;
          end
        end
        StErr: begin
          if (ns_pulse) begin
            a_d     = '0;
            b_d     = '0;
            state_d = StEnterA;
          end
        end
        default: state_d = StEnterA;
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    start_d = (state_d == StIssue);
    disp_d  = disp_q;
    stage_d = 5'b00001;
    case (state_d)
      StEnterA: begin
        disp_d  = a_d;
        stage_d = 5'b00001;
      end
      StEnterB: begin
        disp_d  = b_d;
        stage_d = 5'b00010;
      end
      StIssue, StWait: stage_d = 5'b00100;
      StShow: begin
        disp_d  = res_d;
        stage_d = 5'b01000;
      end
      StErr: begin
        disp_d  = {DIGITS{4'hE}};
        stage_d = 5'b10000;
      end
      default: stage_d = 5'b00001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEnterA;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      stage_q <= 5'b00001;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      stage_q <= stage_d;
      start_q <= start_d;
      clr_q   <= clr_d;
    end
  end

  assign mac_a       = a_q;
  assign mac_b       = b_q;
  assign mac_start   = start_q;
  assign mac_clr_acc = clr_q;
  assign disp_value  = disp_q;
  assign stage_out   = stage_q;

endmodule

// File: doc/mac_entry_sequencer.md
# mac_entry_sequencer

Controller that sequences the FP MAC datapath from front-panel input. It collects two 16-bit half-precision operands from debounced keypad hex digits and steps through entry on next-step pulses. It issues one MAC operation, waits for completion with a timeout, and presents operands, results or an error code to the 4-digit hex display and the 5-bit stage indicator.

## Interface
- `DIGITS`, 4: hex digits per operand; operand width is `4*DIGITS`.
- `MAC_TIMEOUT`, 64: maximum number of WAIT cycles before an error is declared.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: one-cycle pulse; a keypad digit is available.
- `key_code`  in  4: hex digit 0x0–0xF; valid only when `key_valid` is high.
- `ns_pulse`  in  1: one-cycle, debounced next-step pulse.
- `acc_clr`  in  1: one-cycle pulse; clears the accumulator and restarts entry.
- `mac_a`, `mac_b`  out  16 each: operands to the MAC; held stable from ISSUE through WAIT.
- `mac_start`  out  1: one-cycle start strobe to the MAC.
- `mac_clr_acc`  out  1: one-cycle accumulator-clear strobe to the MAC.
- `mac_done`  in  1: MAC completion pulse.
- `mac_result`  in  16: MAC accumulator value; valid while `mac_done` is high.
- `disp_value`  out  16: value for the 4 hex digits; `[3:0]` drives the rightmost digit.
- `stage_out`  out  5: one-hot stage indicator.

## Operation
States are ENTER_A, ENTER_B, ISSUE, WAIT, SHOW and ERR.

- **ENTER_A**
  - `key_valid`: `a <= {a[11:0], key_code}`. A 5th or later digit shifts the oldest digit out.
  - `ns_pulse`: clear `b` and go to ENTER_B.
  - `disp_value = a`.
- **ENTER_B**
  - `key_valid`: shift into `b` the same way.
  - `ns_pulse`: go to ISSUE.
  - `disp_value = b`.
- **ISSUE**
  - Assert `mac_start` for exactly one cycle, then go to WAIT.
  - Clear the timeout counter.
  - `mac_done` is ignored in this state.
- **WAIT**
  - `mac_done`: latch `mac_result` into `res` and go to SHOW.
  - Otherwise increment the counter. When it reaches `MAC_TIMEOUT`, go to ERR.
  - `key_valid` and `ns_pulse` are ignored.
- **SHOW**
  - `disp_value = res`.
  - `ns_pulse`: clear `a` and go to ENTER_A.
  - Keys are ignored.
- **ERR**
  - `disp_value = 16'hEEEE`.
  - `ns_pulse`: clear `a` and `b` and go to ENTER_A.
  - Keys are ignored.

Priority within a cycle is `acc_clr` > `ns_pulse` > `key_valid`. A key arriving in the same cycle as `ns_pulse` is dropped.

`acc_clr` behaves the same in every state, including WAIT and ERR:
- Pulse `mac_clr_acc` for one cycle.
- Clear `a`, `b` and `res`.
- Go to ENTER_A.
- A `mac_done` arriving later is ignored.

`mac_done` and timeout in the same cycle: `mac_done` wins.

`stage_out` encoding:
- ENTER_A: `00001`
- ENTER_B: `00010`
- ISSUE and WAIT: `00100`
- SHOW: `01000`
- ERR: `10000`

`mac_a` = `a` and `mac_b` = `b` at all times.

## Timing
- All outputs are registered.
- Reset values:
  - State ENTER_A.
  - `a`, `b`, `res`, `disp_value` = 0.
  - `mac_start` = `mac_clr_acc` = 0.
  - `stage_out` = `00001`.
  - Timeout counter = 0.
- Reset takes effect on the next edge from any state. An in-flight MAC result is discarded and no strobe is issued.
- `key_valid` at cycle t: `disp_value` is updated at t+1.
- `ns_pulse` at cycle t: state and `stage_out` change at t+1.
- `ns_pulse` in ENTER_B at t: state is ISSUE at t+1 and `mac_start` is high during t+1 only.
- WAIT is entered at t+2 (relative to that `ns_pulse`). `mac_done` at WAIT cycle k gives SHOW and `disp_value = res` at k+1.
- Timeout: with no `mac_done`, ERR is entered exactly `MAC_TIMEOUT` cycles after entering WAIT.
- `acc_clr` at t: `mac_clr_acc` is high during t+1 and state is ENTER_A at t+1.

## Test plan
- Reset, then keys 3,C,0,0 → `disp_value` = `3C00`, `stage_out` = `00001`. Then `ns_pulse`, keys 4,0,0,0 → `disp_value` = `4000`, `stage_out` = `00010`.
- Continue with `ns_pulse` → exactly one `mac_start` cycle with `mac_a` = `3C00`, `mac_b` = `4000`. Model returns `mac_done` 5 cycles later with `mac_result` = `4000` → `disp_value` = `4000`, `stage_out` = `01000`. Then `ns_pulse` → ENTER_A with `disp_value` = `0000`.
- Keys 1,2,3,4,5 in ENTER_A → `disp_value` = `2345`. A key in the same cycle as `ns_pulse` → that key is absent from both `a` and `b`.
- No `mac_done` after issue → ERR exactly 64 cycles after entering WAIT, `disp_value` = `EEEE`, `stage_out` = `10000`. Then `ns_pulse` → ENTER_A. `mac_done` on the 64th WAIT cycle → SHOW instead of ERR.
- `acc_clr` during WAIT → one-cycle `mac_clr_acc`, ENTER_A with `a` = `b` = 0. A late `mac_done` → no state change.
- `rst` asserted during WAIT and during ERR → all outputs at reset values next cycle, and no `mac_start` pulse is observed.
